// File: rtl/cnn_mac_acc_relu.sv
// Accumulates signed products over one kernel window, adds the channel bias,
// requantizes with a rounding shift, applies ReLU/saturation and emits one activation.
module cnn_mac_acc_relu #(
  parameter int PROD_WIDTH = 22,
  parameter int ACC_WIDTH  = 32,
  parameter int BIAS_WIDTH = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 8,
  parameter int KERNEL_LEN = 25
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic signed [PROD_WIDTH-1:0] in_prod,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  output logic        [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         len_err,
  output logic                         acc_ovf
);

  localparam int CNT_W = $clog2(KERNEL_LEN + 1);
  localparam int SW    = ACC_WIDTH + 2;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0]        RND     = SW'(64'sd1 << (SHIFT - 1));
  localparam logic signed [SW-1:0]        OUT_MAX = SW'((64'sd1 << (OUT_WIDTH - 1)) - 64'sd1);

  typedef enum logic [1:0] {S_ACC, S_POST, S_OUT} state_t;

  state_t                        state;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic        [CNT_W-1:0]       beat_cnt;

  logic signed [ACC_WIDTH:0]     acc_sum;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic                          acc_clamp;
  logic                          len_bad;
  logic signed [SW-1:0]          s_ext;
  logic signed [SW-1:0]          rnd;
  logic signed [SW-1:0]          shifted;
  logic        [OUT_WIDTH-1:0]   act;

  assign in_ready = (state == S_ACC) && !ap_rst;

  // One guard bit is enough to detect overflow of a single product add.
  always_comb begin
    acc_sum   = {acc[ACC_WIDTH-1], acc}
              + {{(ACC_WIDTH+1-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
    acc_clamp = acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1];
    acc_next  = acc_sum[ACC_WIDTH-1:0];
    if (acc_clamp) begin
      acc_next = acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    len_bad = ({1'b0, beat_cnt} + (CNT_W+1)'(1)) != (CNT_W+1)'(KERNEL_LEN);
  end

  // Two extra bits keep bias add and rounding offset free of overflow.
  always_comb begin
    s_ext   = {{2{acc[ACC_WIDTH-1]}}, acc}
            + {{(SW-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
    rnd     = s_ext + RND;
    shifted = rnd >>> SHIFT;
    if (shifted[SW-1]) begin
      act = '0;
    end else if (shifted > OUT_MAX) begin
      act = OUT_MAX[OUT_WIDTH-1:0];
    end else begin
      act = shifted[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= S_ACC;
      acc       <= '0;
      beat_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      len_err   <= 1'b0;
      acc_ovf   <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (in_valid) begin
            acc <= acc_next;
            if (acc_clamp) acc_ovf <= 1'b1;
            if (beat_cnt != {CNT_W{1'b1}}) beat_cnt <= beat_cnt + CNT_W'(1);
            if (in_last) begin
              state <= S_POST;
              if (len_bad) len_err <= 1'b1;
            end
          end
        end
        S_POST: begin
          out_data  <= act;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            beat_cnt  <= '0;
            state     <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_mac_acc_relu.sv
// Directed bench: main instance with KERNEL_LEN=4, second instance with a
// 24-bit accumulator to exercise saturation.
module tb_cnn_mac_acc_relu;

  logic               ap_clk;
  logic               ap_rst;
  logic signed [21:0] in_prod;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic signed [15:0] bias;
  logic        [7:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               len_err;
  logic               acc_ovf;

  logic               in_valid2;
  logic               in_last2;
  logic               in_ready2;
  logic        [7:0]  out_data2;
  logic               out_valid2;
  logic               out_ready2;
  logic               len_err2;
  logic               acc_ovf2;

  int tests_run;
  int tests_failed;

  cnn_mac_acc_relu #(
    .PROD_WIDTH(22), .ACC_WIDTH(32), .BIAS_WIDTH(16),
    .OUT_WIDTH(8), .SHIFT(8), .KERNEL_LEN(4)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_prod(in_prod), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .bias(bias), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .len_err(len_err), .acc_ovf(acc_ovf)
  );

  cnn_mac_acc_relu #(
    .PROD_WIDTH(22), .ACC_WIDTH(24), .BIAS_WIDTH(16),
    .OUT_WIDTH(8), .SHIFT(8), .KERNEL_LEN(5)
  ) dut24 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_prod(in_prod), .in_valid(in_valid2),
    .in_last(in_last2), .in_ready(in_ready2), .bias(bias), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .len_err(len_err2), .acc_ovf(acc_ovf2)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_beat(input logic signed [21:0] p, input logic last);
    in_prod  = p;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drive_window(input int n, input logic signed [21:0] p);
    for (int i = 0; i < n; i++) drive_beat(p, i == n - 1);
  endtask

  task automatic wait_out(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    tests_run++; if (out_data !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %0d expected 0", out_data); end
    tests_run++; if (len_err !== 1'b0 || acc_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags: got len_err=%0b acc_ovf=%0b expected 0/0", len_err, acc_ovf); end
    ap_rst = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_release_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    bit got;
    bias = 16'sd0;
    drive_window(4, 22'sd256);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_post_valid: got %0b expected 0", out_valid); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_post_ready: got %0b expected 0", in_ready); end
    @(posedge ap_clk); #1;
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_latency: got %0b expected 1", out_valid); end
    wait_out(got);
    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_timeout: got %0b expected 1", got); end
    tests_run++; if (out_data !== 8'd4) begin tests_failed++; $display("[TB] FAIL basic_data: got %0d expected 4", out_data); end
    tests_run++; if (len_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_len_err: got %0b expected 0", len_err); end
    handshake();
  endtask

  task automatic test_rounding();
    bit got;
    bias = 16'sd0;
    drive_beat(22'sd100, 1'b0);
    drive_beat(22'sd100, 1'b0);
    drive_beat(22'sd100, 1'b0);
    drive_beat(22'sd84, 1'b1);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd2) begin tests_failed++; $display("[TB] FAIL round_384: got %0d valid %0b expected 2", out_data, got); end
    handshake();
    bias = 16'sd640;
    drive_window(4, 22'sd0);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd3) begin tests_failed++; $display("[TB] FAIL round_bias640: got %0d valid %0b expected 3", out_data, got); end
    handshake();
    bias = 16'sd128;
    drive_window(4, 22'sd0);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd1) begin tests_failed++; $display("[TB] FAIL round_half_up: got %0d valid %0b expected 1", out_data, got); end
    handshake();
    bias = 16'sd127;
    drive_window(4, 22'sd0);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd0) begin tests_failed++; $display("[TB] FAIL round_below_half: got %0d valid %0b expected 0", out_data, got); end
    handshake();
  endtask

  task automatic test_relu_sat();
    bit got;
    bias = 16'sd100;
    drive_window(4, -22'sd1000);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd0) begin tests_failed++; $display("[TB] FAIL relu_neg: got %0d valid %0b expected 0", out_data, got); end
    handshake();
    bias = 16'sd0;
    drive_window(4, 22'sd1048576);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd127) begin tests_failed++; $display("[TB] FAIL sat_high: got %0d valid %0b expected 127", out_data, got); end
    handshake();
    bias = 16'sd32256;
    drive_window(4, 22'sd0);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd126) begin tests_failed++; $display("[TB] FAIL sat_below_max: got %0d valid %0b expected 126", out_data, got); end
    handshake();
    bias = 16'sd0;
  endtask

  task automatic test_backpressure();
    bit got;
    drive_window(4, 22'sd256);
    wait_out(got);
    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_timeout: got %0b expected 1", got); end
    in_prod  = 22'sd1000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk); #1;
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_in_ready[%0d]: got %0b expected 0", i, in_ready); end
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_out_valid[%0d]: got %0b expected 1", i, out_valid); end
      tests_run++; if (out_data !== 8'd4) begin tests_failed++; $display("[TB] FAIL bp_out_data[%0d]: got %0d expected 4", i, out_data); end
    end
    in_valid = 1'b0;
    handshake();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release_valid: got %0b expected 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release_ready: got %0b expected 1", in_ready); end
    drive_beat(22'sd100, 1'b0);
    drive_beat(22'sd100, 1'b0);
    drive_beat(22'sd100, 1'b0);
    drive_beat(22'sd84, 1'b1);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd2) begin tests_failed++; $display("[TB] FAIL bp_next_window: got %0d valid %0b expected 2", out_data, got); end
    handshake();
  endtask

  task automatic test_len_err();
    bit got;
    drive_window(3, 22'sd256);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd3) begin tests_failed++; $display("[TB] FAIL len_short_data: got %0d valid %0b expected 3", out_data, got); end
    tests_run++; if (len_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL len_short_flag: got %0b expected 1", len_err); end
    handshake();
    drive_window(4, 22'sd256);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd4) begin tests_failed++; $display("[TB] FAIL len_good_data: got %0d valid %0b expected 4", out_data, got); end
    tests_run++; if (len_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL len_sticky: got %0b expected 1", len_err); end
    handshake();
    do_reset();
    tests_run++; if (len_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL len_reset_clear: got %0b expected 0", len_err); end
    drive_beat(22'sd512, 1'b1);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd2) begin tests_failed++; $display("[TB] FAIL len_single_data: got %0d valid %0b expected 2", out_data, got); end
    tests_run++; if (len_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL len_single_flag: got %0b expected 1", len_err); end
    handshake();
    drive_window(5, 22'sd0);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd0) begin tests_failed++; $display("[TB] FAIL len_long_data: got %0d valid %0b expected 0", out_data, got); end
    handshake();
  endtask

  task automatic test_acc_ovf();
    bit got;
    do_reset();
    bias      = 16'sd0;
    in_prod   = -22'sd2097152;
    in_valid2 = 1'b1;
    in_last2  = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1;
    tests_run++; if (acc_ovf2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_at_min: got %0b expected 0", acc_ovf2); end
    in_last2 = 1'b1;
    @(posedge ap_clk); #1;
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    tests_run++; if (acc_ovf2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_flag: got %0b expected 1", acc_ovf2); end
    @(posedge ap_clk); #1;
    tests_run++; if (out_valid2 !== 1'b1 || out_data2 !== 8'd0) begin tests_failed++; $display("[TB] FAIL ovf_data: got %0d valid %0b expected 0", out_data2, out_valid2); end
    tests_run++; if (len_err2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_len_err: got %0b expected 0", len_err2); end
    tests_run++; if (acc_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_other_inst: got %0b expected 0", acc_ovf); end
    out_ready2 = 1'b1;
    @(posedge ap_clk); #1;
    out_ready2 = 1'b0;
    tests_run++; if (acc_ovf2 !== 1'b1 || in_ready2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_sticky: got ovf=%0b ready=%0b expected 1/1", acc_ovf2, in_ready2); end
  endtask

  task automatic test_reset_mid();
    bit got;
    drive_window(2, 22'sd256);
    wait_out(got);
    handshake();
    drive_beat(22'sd256, 1'b0);
    drive_beat(22'sd256, 1'b0);
    ap_rst = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_ready: got %0b expected 0", in_ready); end
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_valid: got %0b expected 0", out_valid); end
    tests_run++; if (len_err !== 1'b0 || acc_ovf2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_flags: got len_err=%0b acc_ovf=%0b expected 0/0", len_err, acc_ovf2); end
    drive_window(4, 22'sd256);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd4) begin tests_failed++; $display("[TB] FAIL mid_rst_next: got %0d valid %0b expected 4", out_data, got); end
    do_reset();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL out_rst_valid: got %0b expected 0", out_valid); end
    drive_window(4, 22'sd512);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd8) begin tests_failed++; $display("[TB] FAIL out_rst_next: got %0d valid %0b expected 8", out_data, got); end
    tests_run++; if (len_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL out_rst_len_err: got %0b expected 0", len_err); end
    handshake();
  endtask

  task automatic test_gaps();
    bit got;
    drive_beat(22'sd256, 1'b0);
    @(posedge ap_clk); #1;
    drive_beat(22'sd256, 1'b0);
    repeat (3) @(posedge ap_clk);
    #1;
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL gap_hold: got valid=%0b ready=%0b expected 0/1", out_valid, in_ready); end
    drive_beat(22'sd256, 1'b0);
    drive_beat(22'sd256, 1'b1);
    wait_out(got);
    tests_run++; if (got !== 1'b1 || out_data !== 8'd4) begin tests_failed++; $display("[TB] FAIL gap_data: got %0d valid %0b expected 4", out_data, got); end
    tests_run++; if (len_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL gap_len_err: got %0b expected 0", len_err); end
    handshake();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ap_rst       = 1'b1;
    in_prod      = '0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    bias         = '0;
    out_ready    = 1'b0;
    in_valid2    = 1'b0;
    in_last2     = 1'b0;
    out_ready2   = 1'b0;

    test_reset();
    test_basic();
    test_rounding();
    test_relu_sat();
    test_backpressure();
    test_len_err();
    test_acc_ovf();
    test_reset_mid();
    test_gaps();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cnn_mac_acc_relu.md
Name: cnn_mac_acc_relu

Overview:
- Downstream consumer of the signed 8b x 14b convolution multiplier.
- Accumulates a stream of 22-bit signed products over one kernel window (one output pixel), then adds the channel bias.
- Requantizes by rounding right-shift, applies ReLU, saturates to 8 bits and presents the activation on a valid/ready output.
- Sits between the multiplier and the feature-map line buffer of the next layer.

Parameters:
- PROD_WIDTH, 22, signed product width from the multiplier
- ACC_WIDTH, 32, signed accumulator width; must be > PROD_WIDTH
- BIAS_WIDTH, 16, signed bias width; must be < ACC_WIDTH
- OUT_WIDTH, 8, signed activation output width
- SHIFT, 8, requantization right-shift amount; must be >= 1
- KERNEL_LEN, 25, expected products per window, used for length checking

Ports:
- ap_clk  in  1  clock; all logic on the rising edge
- ap_rst  in  1  synchronous active-high reset
- in_prod  in  PROD_WIDTH  signed product
- in_valid  in  1  product valid
- in_last  in  1  marks the final product of a window; qualified by in_valid
- in_ready  out  1  block accepts a product this cycle
- bias  in  BIAS_WIDTH  signed channel bias
- out_data  out  OUT_WIDTH  activation, range 0..2^(OUT_WIDTH-1)-1
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- len_err  out  1  sticky: a window length differed from KERNEL_LEN
- acc_ovf  out  1  sticky: accumulator saturated

Behaviour:
- Reset (ap_rst sampled high): state=ACC, acc=0, beat_cnt=0, out_data=0, out_valid=0, len_err=0, acc_ovf=0. in_ready=0 while ap_rst is high. Reset mid-window or mid-output discards all data; no partial output is produced.
- FSM states: ACC, POST, OUT.
- ACC state:
  - in_ready=1.
  - A beat is accepted when in_valid&in_ready.
  - Each accepted beat does acc <= sat(acc + sext(in_prod)).
  - sat() clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets acc_ovf.
  - beat_cnt increments, saturating at its maximum value; its width is sized to hold KERNEL_LEN.
  - Accepted beat with in_last=1: go to POST. If beat_cnt+1 != KERNEL_LEN, set len_err.
- POST state (1 cycle, in_ready=0):
  - bias is sampled in this cycle and must be stable from the first beat of the window through POST.
  - s = acc + sext(bias), computed at ACC_WIDTH+1 bits (no overflow).
  - r = (s + 2^(SHIFT-1)) >>> SHIFT, an arithmetic shift (round half up).
  - ReLU: r<0 gives 0.
  - Saturation: r > 2^(OUT_WIDTH-1)-1 gives 2^(OUT_WIDTH-1)-1.
  - Register the result into out_data, set out_valid=1, go to OUT.
- OUT state:
  - in_ready=0. out_valid and out_data are held stable until out_ready=1.
  - On out_valid&out_ready: out_valid=0, acc=0, beat_cnt=0, go to ACC. in_ready=1 in the following cycle.
- Latency: last beat accepted at cycle T gives out_valid=1 at T+2. Minimum window period is N+2 cycles for N beats.
- in_valid=0 in ACC: hold state; gaps are allowed anywhere in a window.
- in_last without prior beats (N=1) is legal; len_err is set if KERNEL_LEN != 1.
- out_data keeps its last value after the handshake; it is only meaningful while out_valid=1.
- len_err and acc_ovf clear only on reset.

Test Plan:
- KERNEL_LEN=4, SHIFT=8, bias=0, products 256,256,256,256 (last on 4th) -> out_data=4, out_valid at T+2, len_err=0.
- Products 100,100,100,84, bias=0 -> s=384, (384+128)>>8 -> out_data=2. Products 0,0,0,0 with bias=640 -> out_data=3.
- Products -1000 x4, bias=100 -> ReLU -> out_data=0. Products 2^20 x4 -> 16384 saturates -> out_data=127.
- out_ready held 0 for 5 cycles after out_valid -> in_ready=0 and out_data stable throughout. out_ready=1 -> next cycle in_ready=1, and the next window starts from acc=0.
- Last asserted on the 3rd beat with KERNEL_LEN=4 -> output still produced, len_err=1 and stays 1 across later good windows until ap_rst.
- ACC_WIDTH=24, products -2^21 x5 -> acc clamps at -8388608, acc_ovf=1, out_data=0.
- ap_rst asserted after 2 beats -> out_valid=0, acc cleared, flags cleared; a subsequent full window of 256 x4 gives 4.
